mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port Load_Clear, input, 1 bit: synchronized, active-high request to load the multiplier into B and clear X/A.
REQ-004 The block SHALL have port Run, input, 1 bit: synchronized, active-high level start request.
REQ-005 The block SHALL have port M, input, 1 bit: current multiplier LSB (B[0]) from the register unit.
REQ-006 The block SHALL have port Ld_B, output, 1 bit: load the switch value into register B.
REQ-007 The block SHALL have port Clear_XA, output, 1 bit: clear the X flop and register A.
REQ-008 The block SHALL have port Add_En, output, 1 bit: load A with A+S and update X.
REQ-009 The block SHALL have port Sub_En, output, 1 bit: load A with A-S and update X.
REQ-010 The block SHALL have port Shift_En, output, 1 bit: arithmetic right shift of X:A:B by one.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while a multiply sequence is in progress.
REQ-012 The block SHALL have port Done, output, 1 bit: high while the result is held.
REQ-013 The block SHALL have port Count, output, 3 bits: current iteration index, 0..7.

Function
REQ-014 The FSM SHALL have states IDLE, CLR, ADD, SHIFT and DONE, plus a 3-bit iteration counter.
REQ-015 In IDLE with Load_Clear=1:
- Ld_B=1 and Clear_XA=1 in that same cycle (combinational decode).
- State remains IDLE.
- Repeat for every cycle Load_Clear stays high.
REQ-016 In IDLE with Run=1 and Load_Clear=0, the FSM SHALL go to CLR on the next edge; Load_Clear=1 has priority and blocks the start.
REQ-017 CLR SHALL last 1 cycle: Clear_XA=1, Count=0, next state ADD.
REQ-018 ADD SHALL last 1 cycle:
- Count<7: Add_En=M, Sub_En=0.
- Count=7: Sub_En=M, Add_En=0 (sign-correction step for two's-complement multiply).
- Next state SHIFT.
REQ-019 SHIFT SHALL last 1 cycle with Shift_En=1.
- Count<7: Count increments, next state ADD.
- Count=7: Count returns to 0, next state DONE.
REQ-020 Cycle timing SHALL be exact. Take cycle 0 as the IDLE cycle in which Run is sampled high.
- CLR = cycle 1.
- ADDi = cycle 2+2i, SHIFTi = cycle 3+2i, for i=0..7.
- DONE is entered at cycle 18.
REQ-021 Busy SHALL be 1 in CLR, ADD and SHIFT, and 0 otherwise.
REQ-022 Done SHALL be 1 only in DONE.
REQ-023 DONE SHALL hold while Run=1 and go to IDLE on the first edge with Run=0; a held Run never starts a second multiply.
REQ-024 Load_Clear SHALL be ignored in CLR, ADD, SHIFT and DONE.
REQ-025 At most one of Add_En, Sub_En and Shift_En SHALL be 1 in any cycle.
REQ-026 Ld_B SHALL be 1 only in IDLE.
REQ-027 Count SHALL be 0 outside ADD and SHIFT.
REQ-028 All outputs SHALL be decoded combinationally from state, Count, M and Load_Clear; there are no registered outputs beyond state and Count.
REQ-029 M SHALL be sampled only during ADD; its value in other states has no effect.

Reset
REQ-030 When Reset_n=0, the block SHALL immediately (asynchronously) force state IDLE and Count=0.
REQ-031 While Reset_n=0, all outputs SHALL be 0 regardless of other inputs.
REQ-032 A reset asserted mid-sequence SHALL abort the sequence; no further enables are issued after release until a new Run.
REQ-033 After Reset_n rises, the first edge SHALL be processed as IDLE.

Verification
REQ-034 The bench SHALL cover the load case: Load_Clear=1 for 1 cycle in IDLE, Run=0 -> Ld_B=1 and Clear_XA=1 for exactly that cycle; Busy=0; state stays IDLE.
REQ-035 The bench SHALL cover the full run: Run=1 held, M sequence per ADD = 1,0,1,1,0,0,1,0 -> Add_En in cycles 2,6,8,14; Sub_En never; Shift_En in cycles 3,5,...,17; Busy in cycles 1-17; Done from cycle 18 until Run=0, then IDLE.
REQ-036 The bench SHALL cover the final subtract: M=1 at every ADD -> Add_En in cycles 2..14 (even cycles) and Sub_En=1 in cycle 16 only; Add_En=0 in cycle 16.
REQ-037 The bench SHALL cover simultaneous requests: Run=1 and Load_Clear=1 together for 3 cycles in IDLE, then Load_Clear=0 -> Ld_B pulses for 3 cycles, no CLR during them; CLR on the cycle after Load_Clear drops.
REQ-038 The bench SHALL cover Load_Clear while busy: Load_Clear=1 during ADD3 -> Ld_B=0 and Clear_XA=0; the sequence completes unchanged.
REQ-039 The bench SHALL cover reset mid-run: Reset_n=0 during SHIFT4 (cycle 11) -> all outputs 0 and Count=0 without waiting for a clock edge; after release with Run=0, IDLE holds.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control sequencer for an 8-bit shift-add two's-complement multiplier:
// clears X/A, then runs eight add/shift pairs (the last add becomes a subtract).
module mult_sequencer (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Load_Clear,
  input  logic       Run,
  input  logic       M,
  output logic       Ld_B,
  output logic       Clear_XA,
  output logic       Add_En,
  output logic       Sub_En,
  output logic       Shift_En,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] Count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'd7;

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] count_reg;
  logic [2:0] count_next;
  logic       last_iter;

  assign last_iter = (count_reg == LAST_ITER);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      count_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        count_next = 3'd0;
        // A pending load always wins over a start request.
        if (Run && !Load_Clear) begin
          state_next = CLR;
        end
      end
      CLR: begin
        count_next = 3'd0;
        state_next = ADD;
      end
      ADD: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        if (last_iter) begin
          count_next = 3'd0;
          state_next = DONE;
        end else begin
          count_next = count_reg + 3'd1;
          state_next = ADD;
        end
      end
      DONE: begin
        count_next = 3'd0;
        if (!Run) begin
          state_next = IDLE;
        end
      end
      default: begin
        count_next = 3'd0;
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    Ld_B     = 1'b0;
    Clear_XA = 1'b0;
    Add_En   = 1'b0;
    Sub_En   = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Load_Clear passes straight through, so it is gated while reset is held.
        Ld_B     = Load_Clear && Reset_n;
        Clear_XA = Load_Clear && Reset_n;
      end
      CLR: begin
        Clear_XA = 1'b1;
        Busy     = 1'b1;
      end
      ADD: begin
        // The MSB of a two's-complement multiplier carries negative weight.
        Add_En = M && !last_iter;
        Sub_En = M && last_iter;
        Busy   = 1'b1;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

  assign Count = count_reg;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a cycle-position model.
module tb_mult_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       Load_Clear;
  logic       Run;
  logic       M;
  logic       Ld_B;
  logic       Clear_XA;
  logic       Add_En;
  logic       Sub_En;
  logic       Shift_En;
  logic       Busy;
  logic       Done;
  logic [2:0] Count;

  mult_sequencer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Load_Clear (Load_Clear),
    .Run        (Run),
    .M          (M),
    .Ld_B       (Ld_B),
    .Clear_XA   (Clear_XA),
    .Add_En     (Add_En),
    .Sub_En     (Sub_En),
    .Shift_En   (Shift_En),
    .Busy       (Busy),
    .Done       (Done),
    .Count      (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output vector layout: {Ld_B, Clear_XA, Add_En, Sub_En, Shift_En, Busy, Done, Count[2:0]}
  typedef struct {
    logic       lc;
    logic       run;
    logic       m;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[24];
  int   n_checks = 0;
  int   n_pass   = 0;
  // Model position: 0 = idle, 1..17 = cycles since Run was accepted, 18 = holding result.
  int   pos      = 0;

  function automatic logic [9:0] dut_vec();
    return {Ld_B, Clear_XA, Add_En, Sub_En, Shift_En, Busy, Done, Count};
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    n_checks++;
    if (dut_vec() === exp) n_pass++;
    else $display("FAIL %s @%0t: got %b required %b (Ld_B,Clr,Add,Sub,Shf,Busy,Done,Count)",
                  name, $time, dut_vec(), exp);
  endtask

  function automatic logic [9:0] model_out(input logic lc, input logic m);
    logic [9:0] e;
    int         i;
    e = '0;
    if (pos == 0) begin
      e[9] = lc;
      e[8] = lc;
    end else if (pos == 1) begin
      e[8] = 1'b1;
      e[4] = 1'b1;
    end else if (pos <= 17) begin
      i = (pos - 2) / 2;
      e[4]   = 1'b1;
      e[2:0] = 3'(i);
      if (pos % 2 == 0) begin
        e[7] = m && (i < 7);
        e[6] = m && (i == 7);
      end else begin
        e[5] = 1'b1;
      end
    end else begin
      e[3] = 1'b1;
    end
    return e;
  endfunction

  task automatic model_step(input logic lc, input logic run);
    if (pos == 0) begin
      if (run && !lc) pos = 1;
    end else if (pos < 18) begin
      pos++;
    end else if (!run) begin
      pos = 0;
    end
  endtask

  // Entered at posedge+1; drives, checks mid-cycle, returns at the next posedge+1.
  task automatic do_cycle(input logic lc, input logic run, input logic m, input string name);
    Load_Clear = lc;
    Run        = run;
    M          = m;
    #3;
    check(name, model_out(lc, m));
    @(posedge Clk);
    model_step(lc, run);
    #1;
  endtask

  task automatic build_table();
    logic [7:0] mseq;
    int         c;
    mseq = 8'b0100_1101;  // M per ADD0..ADD7 = 1,0,1,1,0,0,1,0
    tbl[0] = '{lc: 1'b1, run: 1'b0, m: 1'b0, exp: 10'b11_00000_000};
    tbl[1] = '{lc: 1'b0, run: 1'b0, m: 1'b0, exp: 10'b00_00000_000};
    for (int k = 0; k < 22; k++) begin
      c = k;
      tbl[k+2].lc  = 1'b0;
      tbl[k+2].run = (c <= 19);
      tbl[k+2].m   = 1'b1;
      if (c >= 2 && c <= 17 && c % 2 == 0) tbl[k+2].m = mseq[(c-2)/2];
      tbl[k+2].exp = '0;
      tbl[k+2].exp[8] = (c == 1);
      tbl[k+2].exp[7] = (c == 2) || (c == 6) || (c == 8) || (c == 14);
      tbl[k+2].exp[5] = (c % 2 == 1) && (c >= 3) && (c <= 17);
      tbl[k+2].exp[4] = (c >= 1) && (c <= 17);
      tbl[k+2].exp[3] = (c >= 18) && (c <= 20);
      if (c >= 2 && c <= 17) tbl[k+2].exp[2:0] = 3'((c - 2) / 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lc;
    logic run;
    logic m;

    Reset_n    = 1'b0;
    Load_Clear = 1'b1;
    Run        = 1'b1;
    M          = 1'b1;
    build_table();

    // Reset state: all outputs low even with Load_Clear and Run asserted.
    #2;
    check("reset_hold", 10'd0);
    @(posedge Clk);
    #1;
    check("reset_hold_edge", 10'd0);
    #1;
    Reset_n    = 1'b1;
    Load_Clear = 1'b0;
    Run        = 1'b0;
    M          = 1'b0;
    @(posedge Clk);
    model_step(1'b0, 1'b0);
    #1;
    $display("txn reset: released, idle");

    // Directed table: load pulse, then the full run with M = 1,0,1,1,0,0,1,0.
    for (int k = 0; k < 24; k++) begin
      Load_Clear = tbl[k].lc;
      Run        = tbl[k].run;
      M          = tbl[k].m;
      #3;
      check($sformatf("table[%0d]", k), tbl[k].exp);
      @(posedge Clk);
      model_step(tbl[k].lc, tbl[k].run);
      #1;
    end
    $display("txn table: load case and full run applied");

    // M=1 at every ADD: last add turns into the sign-correction subtract.
    for (int c = 0; c < 22; c++) do_cycle(1'b0, c <= 19, 1'b1, $sformatf("all_ones c%0d", c));
    $display("txn all_ones: final subtract sequence applied");

    // Run and Load_Clear together for 3 cycles: load wins, start follows the drop.
    for (int c = 0; c < 3; c++) do_cycle(1'b1, 1'b1, 1'b0, $sformatf("simul_lc c%0d", c));
    for (int c = 0; c < 21; c++) do_cycle(1'b0, c <= 19, 1'($urandom_range(1)), $sformatf("simul_run c%0d", c));
    $display("txn simultaneous: load priority then run");

    // Load_Clear during ADD3 (cycle 8) must be ignored.
    for (int c = 0; c < 22; c++)
      do_cycle(c == 8, c <= 19, 1'($urandom_range(1)), $sformatf("lc_busy c%0d", c));
    $display("txn lc_busy: load ignored mid-sequence");

    // Reset asserted during SHIFT4 (cycle 11), away from any clock edge.
    for (int c = 0; c < 11; c++) do_cycle(1'b0, 1'b1, 1'($urandom_range(1)), $sformatf("rst_mid c%0d", c));
    Load_Clear = 1'b1;
    Run        = 1'b1;
    M          = 1'b1;
    #1;
    check("rst_mid shift4", model_out(1'b1, 1'b1));
    #1;
    Reset_n = 1'b0;
    pos     = 0;
    #1;
    check("rst_mid async", 10'd0);
    @(posedge Clk);
    #1;
    check("rst_mid held", 10'd0);
    #1;
    Reset_n    = 1'b1;
    Load_Clear = 1'b0;
    Run        = 1'b0;
    @(posedge Clk);
    model_step(1'b0, 1'b0);
    #1;
    for (int c = 0; c < 4; c++) do_cycle(1'b0, 1'b0, 1'($urandom_range(1)), $sformatf("rst_idle c%0d", c));
    $display("txn rst_mid: sequence aborted, idle holds");

    // Randomized traffic, including occasional asynchronous reset pulses.
    for (int c = 0; c < 600; c++) begin
      lc  = ($urandom_range(3) == 0);
      run = ($urandom_range(7) != 0);
      m   = 1'($urandom_range(1));
      if ($urandom_range(63) == 0) begin
        Load_Clear = lc;
        Run        = run;
        M          = m;
        #1;
        Reset_n = 1'b0;
        pos     = 0;
        #1;
        check($sformatf("rand_rst c%0d", c), 10'd0);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        model_step(lc, run);
        #1;
      end else begin
        do_cycle(lc, run, m, $sformatf("rand c%0d", c));
      end
    end
    $display("txn random: 600 cycles applied");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
